// File: rtl/wb_merge.sv
// Writeback stage: registered regfile write port, load extraction, and an
// in-order MDU result queue. Optional `WB_INSTRET_EN adds a 64-bit instret.
module wb_merge #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MEM_WB_regwrite,
    input  logic [4:0]      MEM_WB_rd,
    input  logic [XLEN-1:0] MEM_WB_result,
    input  logic            MEM_WB_memread,
    input  logic [2:0]      MEM_WB_funct3,
    input  logic [1:0]      MEM_WB_addr_lo,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_result,
    output logic            mdu_ready,
    input  logic [4:0]      hazard_rs1,
    input  logic [4:0]      hazard_rs2,
    output logic            hazard_stall,
    output logic            reg_write_enable,
    output logic [4:0]      reg_write_addr,
    output logic [XLEN-1:0] reg_write_data
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [31:0]     word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] wb_data;
    logic            pipe_real;

    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0] vld_q, vld_d, kill_q, kill_d;
    logic [4:0]      rd_q [DEPTH];
    logic [4:0]      rd_d [DEPTH];
    logic [XLEN-1:0] dat_q [DEPTH];
    logic [XLEN-1:0] dat_d [DEPTH];

    logic            en_q, en_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            full, empty, enq, pop, head_live;
    logic [AW-1:0]   widx, ridx;

    always_comb begin
        word    = MEM_WB_result[31:0];
        ld_byte = word[{MEM_WB_addr_lo, 3'b000} +: 8];
        ld_half = word[{MEM_WB_addr_lo[1], 4'b0000} +: 16];
        wb_data = MEM_WB_result;
        if (MEM_WB_memread) begin
            unique case (MEM_WB_funct3)
                3'b000:  wb_data = XLEN'($signed(ld_byte));
                3'b001:  wb_data = XLEN'($signed(ld_half));
                3'b010:  wb_data = XLEN'($signed(word));
                3'b100:  wb_data = XLEN'(ld_byte);
                3'b101:  wb_data = XLEN'(ld_half);
                default: wb_data = MEM_WB_result;
            endcase
        end
    end

    assign pipe_real = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);
    assign widx      = wptr_q[AW-1:0];
    assign ridx      = rptr_q[AW-1:0];
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
    assign mdu_ready = !full;
    assign enq       = mdu_valid && !full;
    assign pop       = !pipe_real && !empty;
    assign head_live = vld_q[ridx] && !kill_q[ridx];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        vld_d  = vld_q;
        kill_d = kill_q;
        rd_d   = rd_q;
        dat_d  = dat_q;
        // A newer pipeline write to the same rd makes queued results stale
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_real && vld_q[i] && rd_q[i] == MEM_WB_rd)
                kill_d[i] = 1'b1;
        end
        if (enq) begin
            vld_d[widx]  = 1'b1;
            kill_d[widx] = (mdu_rd == 5'd0) ||
                           (pipe_real && mdu_rd == MEM_WB_rd);
            rd_d[widx]   = mdu_rd;
            dat_d[widx]  = mdu_result;
            wptr_d       = wptr_q + PTR_ONE;
        end
        if (pop) begin
            vld_d[ridx]  = 1'b0;
            kill_d[ridx] = 1'b0;
            rptr_d       = rptr_q + PTR_ONE;
        end
    end

    always_comb begin
        en_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (pipe_real) begin
            en_d   = 1'b1;
            addr_d = MEM_WB_rd;
            data_d = wb_data;
        end else if (pop && head_live) begin
            en_d   = 1'b1;
            addr_d = rd_q[ridx];
            data_d = dat_q[ridx];
        end
    end

    always_comb begin
        hazard_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i] && rd_q[i] != 5'd0 &&
                (rd_q[i] == hazard_rs1 || rd_q[i] == hazard_rs2))
                hazard_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
            kill_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                dat_q[i] <= '0;
            end
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            vld_q  <= vld_d;
            kill_q <= kill_d;
            rd_q   <= rd_d;
            dat_q  <= dat_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign reg_write_enable = en_q;
    assign reg_write_addr   = addr_q;
    assign reg_write_data   = data_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + {63'd0, MEM_WB_regwrite}
                              + {63'd0, pop && head_live};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Directed self-checking bench for wb_merge (XLEN=32, DEPTH=4).
module tb_wb_merge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_result;
    logic        MEM_WB_memread;
    logic [2:0]  MEM_WB_funct3;
    logic [1:0]  MEM_WB_addr_lo;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_result;
    logic        mdu_ready;
    logic [4:0]  hazard_rs1, hazard_rs2;
    logic        hazard_stall;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wb_merge #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_memread(MEM_WB_memread),
        .MEM_WB_funct3(MEM_WB_funct3), .MEM_WB_addr_lo(MEM_WB_addr_lo),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_result(mdu_result),
        .mdu_ready(mdu_ready),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .hazard_stall(hazard_stall),
        .reg_write_enable(reg_write_enable),
        .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [4:0] a,
                      input logic [31:0] d);
        chk({tag, "_en"}, 64'(reg_write_enable), 64'd1);
        chk({tag, "_addr"}, 64'(reg_write_addr), 64'(a));
        chk({tag, "_data"}, 64'(reg_write_data), 64'(d));
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd,
                        input logic [31:0] res);
        MEM_WB_regwrite = we;
        MEM_WB_rd       = rd;
        MEM_WB_result   = res;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd,
                       input logic [31:0] res);
        mdu_valid  = v;
        mdu_rd     = rd;
        mdu_result = res;
    endtask

    initial begin
        rst_n = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        MEM_WB_memread = 1'b0;
        MEM_WB_funct3  = 3'd0;
        MEM_WB_addr_lo = 2'd0;
        mdu(1'b0, 5'd0, 32'd0);
        hazard_rs1 = 5'd0;
        hazard_rs2 = 5'd0;
        #3;
        chk("rst_en", 64'(reg_write_enable), 64'd0);
        chk("rst_addr", 64'(reg_write_addr), 64'd0);
        chk("rst_data", 64'(reg_write_data), 64'd0);
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        chk("rst_stall", 64'(hazard_stall), 64'd0);
        tick();
        rst_n = 1'b1;

        // basic one-cycle pipeline write
        pipe(1'b1, 5'd5, 32'h1234);
        tick();
        wr("pipe5", 5'd5, 32'h1234);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("pipe5_off", 64'(reg_write_enable), 64'd0);

        // rd=0 write is dropped
        pipe(1'b1, 5'd0, 32'hDEAD);
        tick();
        chk("rd0_drop", 64'(reg_write_enable), 64'd0);

        // load extraction
        MEM_WB_memread = 1'b1;
        pipe(1'b1, 5'd1, 32'h80FF7F01);
        MEM_WB_funct3 = 3'b000; MEM_WB_addr_lo = 2'd3;
        tick(); wr("lb3", 5'd1, 32'hFFFFFF80);
        MEM_WB_funct3 = 3'b100; MEM_WB_addr_lo = 2'd1;
        tick(); wr("lbu1", 5'd1, 32'h0000007F);
        MEM_WB_funct3 = 3'b101; MEM_WB_addr_lo = 2'd2;
        tick(); wr("lhu2", 5'd1, 32'h000080FF);
        MEM_WB_funct3 = 3'b001; MEM_WB_addr_lo = 2'd0;
        tick(); wr("lh0", 5'd1, 32'h00007F01);
        MEM_WB_funct3 = 3'b010; MEM_WB_addr_lo = 2'd0;
        tick(); wr("lw", 5'd1, 32'h80FF7F01);
        MEM_WB_funct3 = 3'b000; MEM_WB_addr_lo = 2'd0;
        tick(); wr("lb0", 5'd1, 32'h00000001);
        MEM_WB_memread = 1'b0;
        MEM_WB_funct3  = 3'b000;
        tick(); wr("nomem", 5'd1, 32'h80FF7F01);

        // MDU result waits behind three pipeline writes
        pipe(1'b1, 5'd3, 32'hAAAA);
        mdu(1'b1, 5'd7, 32'h77);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        hazard_rs1 = 5'd7;
        #1;
        wr("arb_p1", 5'd3, 32'hAAAA);
        chk("arb_stall1", 64'(hazard_stall), 64'd1);
        tick(); wr("arb_p2", 5'd3, 32'hAAAA);
        chk("arb_stall2", 64'(hazard_stall), 64'd1);
        tick(); wr("arb_p3", 5'd3, 32'hAAAA);
        chk("arb_stall3", 64'(hazard_stall), 64'd1);
        pipe(1'b0, 5'd0, 32'd0);
        tick(); wr("arb_mdu", 5'd7, 32'h77);
        chk("arb_stall_off", 64'(hazard_stall), 64'd0);
        hazard_rs1 = 5'd0;
        tick();
        chk("arb_idle", 64'(reg_write_enable), 64'd0);

        // fill queue while pipeline blocks pops
        pipe(1'b1, 5'd1, 32'h1);
        for (int i = 0; i < 4; i++) begin
            mdu(1'b1, 5'(10 + i), 32'(16 * (10 + i)));
            tick();
            if (i == 2) chk("fill_ready3", 64'(mdu_ready), 64'd1);
        end
        chk("full_ready", 64'(mdu_ready), 64'd0);
        mdu(1'b1, 5'd14, 32'hEEEE);
        tick();
        chk("full_hold", 64'(mdu_ready), 64'd0);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        wr("drain10", 5'd10, 32'd160);
        chk("pop_ready", 64'(mdu_ready), 64'd1);
        mdu(1'b0, 5'd0, 32'd0);
        tick(); wr("drain11", 5'd11, 32'd176);
        tick(); wr("drain12", 5'd12, 32'd192);
        tick(); wr("drain13", 5'd13, 32'd208);
        tick();
        chk("drain_empty", 64'(reg_write_enable), 64'd0);

        // WAW kill of a queued entry
        pipe(1'b1, 5'd1, 32'h1);
        mdu(1'b1, 5'd9, 32'h99);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        hazard_rs2 = 5'd9;
        #1;
        chk("kill_stall_on", 64'(hazard_stall), 64'd1);
        pipe(1'b1, 5'd9, 32'h1999);
        tick(); wr("kill_pipe", 5'd9, 32'h1999);
        chk("kill_stall_off", 64'(hazard_stall), 64'd0);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("kill_nowrite", 64'(reg_write_enable), 64'd0);

        // same-cycle enqueue and kill
        pipe(1'b1, 5'd9, 32'h2999);
        mdu(1'b1, 5'd9, 32'h98);
        tick(); wr("samek_pipe", 5'd9, 32'h2999);
        mdu(1'b0, 5'd0, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        chk("samek_stall", 64'(hazard_stall), 64'd0);
        tick();
        chk("samek_nowrite", 64'(reg_write_enable), 64'd0);
        hazard_rs2 = 5'd0;

        // mdu rd=0 accepted but never written
        mdu(1'b1, 5'd0, 32'h55);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        tick();
        chk("mdu_rd0", 64'(reg_write_enable), 64'd0);

        // async reset with three queued entries
        pipe(1'b1, 5'd1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            mdu(1'b1, 5'(20 + i), 32'(i + 1));
            tick();
        end
        mdu(1'b0, 5'd0, 32'd0);
        hazard_rs1 = 5'd20;
        #1;
        chk("prerst_stall", 64'(hazard_stall), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_en", 64'(reg_write_enable), 64'd0);
        chk("mrst_addr", 64'(reg_write_addr), 64'd0);
        chk("mrst_data", 64'(reg_write_data), 64'd0);
        chk("mrst_ready", 64'(mdu_ready), 64'd1);
        chk("mrst_stall", 64'(hazard_stall), 64'd0);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 64'(reg_write_enable), 64'd0);
        end
        chk("post_rst_stall", 64'(hazard_stall), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_merge.md
# wb_merge

Parametrised writeback stage that replaces the purely combinational MEM/WB-to-register-file pass-through. It registers the register-file write port, extracts and sign-extends load data, and merges results from a long-latency unit (multiply/divide) through a small in-order queue that shares the single register-file write port with the main pipeline. It sits between the MEM/WB pipeline register plus MDU result bus on one side and the register file and hazard unit on the other.

## Interface
- XLEN, 32: datapath width; must be >= 32; load lanes come from bits [31:0].
- DEPTH, 4: MDU queue entries; power of two, >= 2.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- MEM_WB_regwrite  in  1  pipeline instruction writes rd
- MEM_WB_rd  in  5  pipeline destination register
- MEM_WB_result  in  XLEN  ALU result, or raw memory word when MEM_WB_memread=1
- MEM_WB_memread  in  1  result is load data needing extraction
- MEM_WB_funct3  in  3  load type
- MEM_WB_addr_lo  in  2  low address bits of load
- mdu_valid  in  1  MDU offers a result
- mdu_rd  in  5  MDU destination
- mdu_result  in  XLEN  MDU result
- mdu_ready  out  1  queue accepts; equals !full
- hazard_rs1, hazard_rs2  in  5 each  ID-stage source registers
- hazard_stall  out  1  a live queued entry targets a nonzero rs1/rs2
- reg_write_enable  out  1  registered write strobe
- reg_write_addr  out  5  registered write address
- reg_write_data  out  XLEN  registered write data

## Operation
- Load extraction (memread=1): byte = word >> 8*addr_lo; half = word >> 16*addr_lo[1]. funct3 000 sign-extend byte, 001 sign-extend half, 010 word (sign-extend to XLEN), 100 zero-extend byte, 101 zero-extend half; 011/110/111 pass word unchanged. memread=0: result passes unchanged.
- Pipeline write is "real" when MEM_WB_regwrite=1 and MEM_WB_rd!=0. rd=0 writes are dropped, never presented.
- Queue: circular buffer, valid+kill bit per entry, read/write pointers with wrap bit. Enqueue when mdu_valid && mdu_ready; mdu_rd=0 results are accepted and immediately marked killed.
- Port arbitration each cycle: real pipeline write wins. Otherwise, if queue non-empty, pop head; head live -> write it, head killed -> pop with no write.
- WAW kill: a real pipeline write to rd X sets kill on every valid queue entry with rd X (including an entry enqueued the same cycle).
- hazard_stall: combinational OR over live (valid, not killed) entries with rd!=0 matching hazard_rs1 or hazard_rs2.

## Timing
- Reset (rst_n low, asynchronous): reg_write_enable=0, reg_write_addr=0, reg_write_data=0, queue empty, mdu_ready=1, hazard_stall=0. Reset mid-drain discards all queued entries.
- Pipeline write latency: 1 cycle (inputs at edge N appear on reg_write_* after edge N+1). reg_write_enable is high for exactly one cycle per write.
- MDU latency: earliest write 1 cycle after enqueue edge, if no pipeline write that cycle; one pop per cycle max.
- Full: mdu_ready=0 even if a pop happens the same cycle (no same-cycle refill when full). Empty: no pop, enable=0 unless pipeline writes.
- Simultaneous enqueue and pop on non-full queue: both occur; count unchanged.
- Starvation of queue under continuous pipeline writes is permitted; the MDU stalls via mdu_ready.

## Configuration
- WB_INSTRET_EN defined: adds output instret (64 bits), reset 0, incremented by 1 per cycle in which MEM_WB_regwrite=1 (including rd=0) plus 1 per live MDU pop; wraps at 2^64. Undefined: port and counter absent, no other change.

## Test plan
- Reset then MEM_WB_regwrite=1, rd=5, result=0x1234 -> next cycle enable=1, addr=5, data=0x1234; following cycle enable=0.
- Load word 0x80FF7F01, funct3=000, addr_lo=3 -> 0xFFFFFF80; funct3=100, addr_lo=1 -> 0x7F; funct3=101, addr_lo=2 -> 0x80FF.
- Enqueue MDU rd=7 while pipeline writes rd=3 for 3 cycles -> rd=3 writes first, rd=7 written the cycle after the pipeline goes idle; hazard_stall=1 for rs1=7 until pop.
- Fill DEPTH=4 entries with no pops -> mdu_ready=0; single pop -> mdu_ready=1 next cycle; entries drain in order.
- Queue holds rd=9; pipeline writes rd=9 -> entry killed, hazard_stall for rs2=9 drops, later pop produces no write.
- Assert rst_n low with 3 queued entries -> outputs 0 immediately, queue empty, no writes after release.
